// File: rtl/z80_bus_target.sv
// Z80 CPU-side bus responder: decodes mem/io/int-ack cycles and bridges them to a
// synchronous req/ack backend, stretching the CPU with wait_n until the backend answers.
module z80_bus_target #(
  parameter int unsigned ExtraWait  = 0,
  parameter int unsigned IntAckWait = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_io,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        bus_ack,
  input  logic [7:0]  int_vector,
  output logic        intack
);

  typedef enum logic [2:0] {
    StIdle,
    StAccess,
    StStretch,
    StHold,
    StInta,
    StDrain
  } state_e;

  localparam logic [3:0] ExtraCnt = 4'(ExtraWait);
  localparam logic [3:0] IntCnt   = 4'(IntAckWait);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  cpu_di_q, cpu_di_d;
  logic        wait_n_q, wait_n_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_io_q, bus_io_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        intack_q, intack_d;

  logic strobes_off, data_strobe, is_inta, is_rfsh, is_mem, is_io;

  always_comb begin
    strobes_off = mreq_n & iorq_n;
    data_strobe = ~rd_n | ~wr_n;
    is_inta     = ~m1_n & ~iorq_n;
    is_rfsh     = ~mreq_n & ~rfsh_n;
    is_mem      = ~mreq_n & data_strobe;
    is_io       = ~iorq_n & m1_n & data_strobe;

    state_d     = state_q;
    cnt_d       = cnt_q;
    cpu_di_d    = cpu_di_q;
    wait_n_d    = wait_n_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_io_d    = bus_io_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    intack_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (is_inta) begin
          state_d  = StInta;
          cpu_di_d = int_vector;
          intack_d = 1'b1;
          if (IntCnt != 4'd0) begin
            wait_n_d = 1'b0;
            cnt_d    = IntCnt;
          end
        end else if (is_rfsh) begin
          state_d = StIdle;
        end else if (is_mem || is_io) begin
          state_d     = StAccess;
          bus_addr_d  = A;
          bus_wdata_d = cpu_dout;
          bus_we_d    = ~wr_n;
          bus_io_d    = ~is_mem;
          bus_req_d   = 1'b1;
          wait_n_d    = 1'b0;
        end
      end
      StAccess: begin
        // Ack takes priority over a simultaneous strobe release.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) cpu_di_d = bus_rdata;
          if (ExtraCnt == 4'd0) begin
            wait_n_d = 1'b1;
            state_d  = StHold;
          end else begin
            cnt_d   = ExtraCnt;
            state_d = StStretch;
          end
        end else if (strobes_off) begin
          wait_n_d = 1'b1;
          state_d  = StDrain;
        end
      end
      StStretch: begin
        if (strobes_off) begin
          wait_n_d = 1'b1;
          state_d  = StIdle;
        end else if (cnt_q == 4'd1) begin
          wait_n_d = 1'b1;
          state_d  = StHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (strobes_off) state_d = StIdle;
      end
      StInta: begin
        if (iorq_n) begin
          wait_n_d = 1'b1;
          state_d  = StIdle;
        end else if (!wait_n_q) begin
          if (cnt_q == 4'd1) wait_n_d = 1'b1;
          else               cnt_d    = cnt_q - 4'd1;
        end
      end
      StDrain: begin
        // The request cannot be withdrawn, so wait out the ack and drop its data.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      cpu_di_q    <= 8'hFF;
      wait_n_q    <= 1'b1;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_io_q    <= 1'b0;
      bus_addr_q  <= 16'h0000;
      bus_wdata_q <= 8'h00;
      intack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_di_q    <= cpu_di_d;
      wait_n_q    <= wait_n_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_io_q    <= bus_io_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      intack_q    <= intack_d;
    end
  end

  assign cpu_di    = cpu_di_q;
  assign wait_n    = wait_n_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_io    = bus_io_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign intack    = intack_q;

endmodule

// File: tb/tb_z80_bus_target.sv
// Bench for z80_bus_target: two instances (no extra waits / ExtraWait=2, IntAckWait=3)
// share one CPU and one backend; expectations come from cycle counts relative to detect.
module tb_z80_bus_target;

  localparam int unsigned Ew2 = 2;
  localparam int unsigned Iw2 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  logic [7:0]  int_vector;

  logic [7:0]  cpu_di0, cpu_di2;
  logic        wait_n0, wait_n2, bus_req0, bus_req2, bus_we0, bus_we2;
  logic        bus_io0, bus_io2, intack0, intack2;
  logic [15:0] bus_addr0, bus_addr2;
  logic [7:0]  bus_wdata0, bus_wdata2;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_di0, exp_di2;

  always #5 clk = ~clk;

  z80_bus_target #(.ExtraWait(0), .IntAckWait(0)) dut0 (
    .clk(clk), .reset(reset), .A(A), .cpu_dout(cpu_dout),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .rfsh_n(rfsh_n), .cpu_di(cpu_di0), .wait_n(wait_n0), .bus_req(bus_req0),
    .bus_we(bus_we0), .bus_io(bus_io0), .bus_addr(bus_addr0), .bus_wdata(bus_wdata0),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .int_vector(int_vector), .intack(intack0)
  );

  z80_bus_target #(.ExtraWait(Ew2), .IntAckWait(Iw2)) dut2 (
    .clk(clk), .reset(reset), .A(A), .cpu_dout(cpu_dout),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .rfsh_n(rfsh_n), .cpu_di(cpu_di2), .wait_n(wait_n2), .bus_req(bus_req2),
    .bus_we(bus_we2), .bus_io(bus_io2), .bus_addr(bus_addr2), .bus_wdata(bus_wdata2),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .int_vector(int_vector), .intack(intack2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_strobes();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1;
    rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_wait0"}, 32'(wait_n0), 32'(1));
    check({tag, "_wait2"}, 32'(wait_n2), 32'(1));
    check({tag, "_req0"}, 32'(bus_req0), 32'(0));
    check({tag, "_req2"}, 32'(bus_req2), 32'(0));
    check({tag, "_we"}, 32'({bus_we0, bus_we2}), 32'(0));
    check({tag, "_io"}, 32'({bus_io0, bus_io2}), 32'(0));
    check({tag, "_addr"}, 32'({bus_addr0, bus_addr2}), 32'(0));
    check({tag, "_wdata"}, 32'({bus_wdata0, bus_wdata2}), 32'(0));
    check({tag, "_di"}, 32'({cpu_di0, cpu_di2}), 32'(16'hFFFF));
    check({tag, "_intack"}, 32'({intack0, intack2}), 32'(0));
  endtask

  // One mem/io cycle; 'pre' clocks of address strobe without data strobe precede detect.
  task automatic do_access(input bit io, input bit wr, input logic [15:0] addr,
                           input logic [7:0] wd, input int k, input logic [7:0] rd,
                           input int pre);
    A = addr;
    cpu_dout = wd;
    if (io) iorq_n = 1'b0;
    else    mreq_n = 1'b0;
    for (int p = 0; p < pre; p++) begin
      step();
      check("pre_req", 32'({bus_req0, bus_req2}), 32'(0));
    end
    if (wr) wr_n = 1'b0;
    else    rd_n = 1'b0;
    for (int i = 0; i < k + int'(Ew2) + 1; i++) begin
      bus_ack   = (i == k);
      bus_rdata = (i == k) ? rd : 8'($urandom);
      step();
      if (i == 0) begin
        check("addr", 32'(bus_addr0), 32'(addr));
        check("addr2", 32'(bus_addr2), 32'(addr));
        check("we", 32'(bus_we0), 32'(wr));
        check("io", 32'(bus_io0), 32'(io));
        if (wr) check("wdata", 32'(bus_wdata0), 32'(wd));
      end
      check("req0", 32'(bus_req0), 32'(i < k));
      check("req2", 32'(bus_req2), 32'(i < k));
      check("wait0", 32'(wait_n0), 32'(i >= k));
      check("wait2", 32'(wait_n2), 32'(i >= k + int'(Ew2)));
      if (i == k) begin
        if (!wr) exp_di0 = rd;
        check("di0", 32'(cpu_di0), 32'(exp_di0));
      end
      if (i == k + int'(Ew2)) begin
        if (!wr) exp_di2 = rd;
        check("di2", 32'(cpu_di2), 32'(exp_di2));
      end
    end
    bus_ack = 1'b0;
    release_strobes();
    step();
    check("end_wait", 32'({wait_n0, wait_n2}), 32'(2'b11));
    check("end_req", 32'({bus_req0, bus_req2}), 32'(0));
  endtask

  initial begin
    logic [7:0] r;
    reset = 1'b1;
    A = 16'h0; cpu_dout = 8'h0; bus_rdata = 8'h0; bus_ack = 1'b0; int_vector = 8'h0;
    release_strobes();
    exp_di0 = 8'hFF;
    exp_di2 = 8'hFF;
    @(negedge clk);
    step();
    check_reset_vals("rst");
    reset = 1'b0;
    step();

    // Mem read k=3, IO write k=1.
    do_access(1'b0, 1'b0, 16'h8000, 8'h00, 3, 8'h5A, 0);
    do_access(1'b1, 1'b1, 16'h00FE, 8'h07, 1, 8'h00, 0);

    // Interrupt acknowledge.
    int_vector = 8'hE8;
    m1_n = 1'b0; iorq_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("intack0", 32'(intack0), 32'(i == 0));
      check("intack2", 32'(intack2), 32'(i == 0));
      check("inta_wait0", 32'(wait_n0), 32'(1));
      check("inta_wait2", 32'(wait_n2), 32'(i >= int'(Iw2)));
      check("inta_req", 32'({bus_req0, bus_req2}), 32'(0));
    end
    exp_di0 = 8'hE8;
    exp_di2 = 8'hE8;
    check("inta_di", 32'({cpu_di0, cpu_di2}), 32'({exp_di0, exp_di2}));
    release_strobes();
    step();

    // Refresh, including a stray rd_n low, is ignored.
    A = 16'h007F; mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rfsh_req", 32'({bus_req0, bus_req2}), 32'(0));
      check("rfsh_wait", 32'({wait_n0, wait_n2}), 32'(2'b11));
    end
    release_strobes();
    step();

    // ExtraWait read with k=1, then reset in the middle of the next access.
    do_access(1'b0, 1'b0, 16'h1234, 8'h00, 1, 8'hC3, 0);
    A = 16'h4321; mreq_n = 1'b0; rd_n = 1'b0;
    step();
    check("prerst_req", 32'({bus_req0, bus_req2}), 32'(2'b11));
    reset = 1'b1;
    step();
    exp_di0 = 8'hFF;
    exp_di2 = 8'hFF;
    check_reset_vals("midrst");
    reset = 1'b0;
    release_strobes();
    step();

    // Strobes released in ACCESS: drain until ack 4 clocks later, data discarded.
    r = 8'($urandom);
    A = 16'h2000; mreq_n = 1'b0; rd_n = 1'b0;
    step();
    release_strobes();
    for (int i = 1; i <= 4; i++) begin
      bus_ack = (i == 4);
      bus_rdata = r;
      step();
      check("drain_wait", 32'({wait_n0, wait_n2}), 32'(2'b11));
      check("drain_req0", 32'(bus_req0), 32'(i < 4));
      check("drain_req2", 32'(bus_req2), 32'(i < 4));
      check("drain_di", 32'({cpu_di0, cpu_di2}), 32'({exp_di0, exp_di2}));
    end
    bus_ack = 1'b0;
    do_access(1'b0, 1'b1, 16'h2001, 8'h99, 2, 8'h00, 0);

    // Strobes released during STRETCH: wait_n rises at once.
    r = 8'($urandom);
    A = 16'h3000; mreq_n = 1'b0; rd_n = 1'b0;
    step();
    bus_ack = 1'b1; bus_rdata = r;
    step();
    bus_ack = 1'b0;
    exp_di0 = r;
    exp_di2 = r;
    check("str_wait", 32'({wait_n0, wait_n2}), 32'(2'b10));
    release_strobes();
    step();
    check("str_abort_wait", 32'({wait_n0, wait_n2}), 32'(2'b11));
    check("str_abort_di", 32'({cpu_di0, cpu_di2}), 32'({exp_di0, exp_di2}));
    do_access(1'b1, 1'b0, 16'h00FE, 8'h00, 1, 8'h3C, 0);

    // Randomised accesses; writes may use T2-write strobe timing.
    for (int n = 0; n < 20; n++) begin
      bit io, wr;
      io = 1'($urandom);
      wr = 1'($urandom);
      do_access(io, wr, 16'($urandom), 8'($urandom), int'($urandom_range(1, 5)),
                8'($urandom), wr ? int'($urandom_range(0, 1)) : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
